// File: rtl/capture_controller.sv
// Sample-capture sequencer: loads trigger edges, arms the trigger block, streams samples into
// a circular buffer and stops post_count+1 writes after the trigger. Optional macro: CAPTURE_TIMEOUT_EN.
module capture_controller #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic [SAMPLE_WIDTH-1:0] cfgRising,
  input  logic [SAMPLE_WIDTH-1:0] cfgFalling,
  input  logic [ADDR_WIDTH-1:0]   post_count,
  output logic [SAMPLE_WIDTH-1:0] trigRising,
  output logic [SAMPLE_WIDTH-1:0] trigFalling,
  output logic                    load_trigs,
  output logic                    arm,
  input  logic                    run,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [SAMPLE_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]   trig_addr,
  output logic                    wrapped,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_PRETRIG, S_POST, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   post_q, post_d;
  logic [SAMPLE_WIDTH-1:0] rising_q, rising_d;
  logic [SAMPLE_WIDTH-1:0] falling_q, falling_d;
  logic                    wrapped_q, wrapped_d;
  logic                    write_ok;
  logic                    trig_hit;
  logic                    to_hit;
  logic [ADDR_WIDTH:0]     rem_load;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timed_out_q, timed_out_d;

  // Counter saturates at the limit so the forced trigger fires exactly once per PRETRIG visit.
  assign to_hit = (state_q == S_PRETRIG) && (to_cnt_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_ARM) begin
      to_cnt_d = '0;
    end else if ((state_q == S_PRETRIG) && !to_hit) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign to_hit    = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign trig_hit = run || to_hit;
  // Without a sample this cycle the trigger sample is still to come, so one extra write is owed.
  assign rem_load = valid ? {1'b0, post_q} : ({1'b0, post_q} + (ADDR_WIDTH+1)'(1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    remaining_d = remaining_q;
    post_d      = post_q;
    rising_d    = rising_q;
    falling_d   = falling_q;
    wrapped_d   = wrapped_q;
    write_ok    = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
    timed_out_d = timed_out_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            rising_d  = cfgRising;
            falling_d = cfgFalling;
            post_d    = post_count;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
            timed_out_d = 1'b0;
`endif
            state_d   = S_LOAD;
          end
        end
        S_LOAD: state_d = S_ARM;
        S_ARM:  state_d = S_PRETRIG;
        S_PRETRIG: begin
          write_ok = valid;
          if (trig_hit) begin
            trig_addr_d = wr_ptr_q;
            remaining_d = rem_load;
            state_d     = (rem_load == '0) ? S_DONE : S_POST;
`ifdef CAPTURE_TIMEOUT_EN
            if (to_hit && !run) timed_out_d = 1'b1;
`endif
          end
        end
        S_POST: begin
          write_ok = valid;
          if (valid) begin
            remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
            if (remaining_q == (ADDR_WIDTH+1)'(1)) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (write_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (&wr_ptr_q) wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      remaining_q <= '0;
      post_q      <= '0;
      rising_q    <= '0;
      falling_q   <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      remaining_q <= remaining_d;
      post_q      <= post_d;
      rising_q    <= rising_d;
      falling_q   <= falling_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign trigRising  = rising_q;
  assign trigFalling = falling_q;
  assign load_trigs  = (state_q == S_LOAD);
  assign arm         = (state_q == S_ARM);
  assign busy        = (state_q == S_LOAD) || (state_q == S_ARM) ||
                       (state_q == S_PRETRIG) || (state_q == S_POST);
  assign done        = (state_q == S_DONE);
  assign wr_en       = write_ok && reset;
  assign wr_addr     = wr_ptr_q;
  assign wr_data     = dataIn;
  assign trig_addr   = trig_addr_q;
  assign wrapped     = wrapped_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: table of capture scenarios, randomized captures against a
// write-count model, and hand sequences for abort/reset mid-capture and the PRETRIG timeout.
module tb_capture_controller;
  localparam int SW = 8;
  localparam int AW = 4;
  localparam int TO = 8;
  localparam int DEPTH = 1 << AW;
`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO_LIMIT = TO;
`else
  localparam int TO_LIMIT = 1 << 30;
`endif

  logic          clock = 1'b0;
  logic          reset, start, abort, valid, run;
  logic [SW-1:0] dataIn, cfgRising, cfgFalling;
  logic [AW-1:0] post_count;
  logic [SW-1:0] trigRising, trigFalling, wr_data;
  logic [AW-1:0] wr_addr, trig_addr;
  logic          load_trigs, arm, wr_en, wrapped, busy, done, timed_out;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [AW+SW-1:0] exp_q[$];

  typedef struct {
    int post;
    int pre;
    bit vor;
    int pct;
    int exp_trig;
    bit exp_wrap;
  } vec_t;
  vec_t tbl[6];

  always #5 clock = ~clock;

  capture_controller #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .valid(valid),
    .dataIn(dataIn), .cfgRising(cfgRising), .cfgFalling(cfgFalling), .post_count(post_count),
    .trigRising(trigRising), .trigFalling(trigFalling), .load_trigs(load_trigs), .arm(arm),
    .run(run), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
    .wrapped(wrapped), .busy(busy), .done(done), .timed_out(timed_out), .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int n);
    exp_q.push_back({AW'(n), dataIn});
  endtask

  task automatic drive_sample(input int pct, output bit v);
    v = ($urandom_range(1, 100) <= pct);
    valid = v;
    dataIn = SW'($urandom);
  endtask

  // One full capture; the model is just a count of writes since start.
  task automatic do_capture(input int post, input int pre, input bit vor, input int pct,
                            output int trig_m, output bit wrap_m, output bit forced_m);
    int n, left, c;
    bit v;
    logic [SW-1:0] r, f;
    n = 0;
    c = 0;
    r = SW'($urandom);
    f = SW'($urandom);
    start = 1; abort = 0; cfgRising = r; cfgFalling = f; post_count = AW'(post);
    valid = 1'($urandom); dataIn = SW'($urandom); run = 1'($urandom);
    tick();
    start = 0; post_count = AW'($urandom); cfgRising = SW'($urandom); cfgFalling = SW'($urandom);
    run = 1; valid = 1'($urandom);
    check("load_trigs", 32'(load_trigs), 1);
    check("arm_in_load", 32'(arm), 0);
    check("busy_load", 32'(busy), 1);
    check("done_cleared", 32'(done), 0);
    check("timed_out_cleared", 32'(timed_out), 0);
    check("trigRising", 32'(trigRising), 32'(r));
    check("trigFalling", 32'(trigFalling), 32'(f));
    tick();
    check("arm", 32'(arm), 1);
    check("load_in_arm", 32'(load_trigs), 0);
    run = 1; valid = 1'($urandom);
    tick();
    run = 0;
    while (n < pre && c < TO_LIMIT) begin
      drive_sample(pct, v);
      if (v) begin
        push_exp(n);
        n++;
      end
      c++;
      tick();
    end
    forced_m = (n < pre);
    run = !forced_m;
    if (forced_m) drive_sample(pct, v);
    else begin
      v = vor;
      valid = vor;
      dataIn = SW'($urandom);
    end
    trig_m = n % DEPTH;
    if (v) begin
      push_exp(n);
      n++;
      left = post;
    end else begin
      left = post + 1;
    end
    tick();
    while (left > 0) begin
      drive_sample(pct, v);
      run = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      cfgRising = SW'($urandom);
      cfgFalling = SW'($urandom);
      if (v) begin
        push_exp(n);
        n++;
        left--;
      end
      tick();
    end
    start = 0; run = 1'($urandom); valid = 1'($urandom); dataIn = SW'($urandom);
    wrap_m = (n >= DEPTH);
    check("done", 32'(done), 1);
    check("busy_done", 32'(busy), 0);
    check("trig_addr", 32'(trig_addr), 32'(trig_m));
    check("wrapped", 32'(wrapped), 32'(wrap_m));
    check("timed_out", 32'(timed_out), 32'(forced_m));
    check("trig_kept", 32'(trigRising), 32'(r));
    check("missing_writes", 32'(exp_q.size()), 0);
    tick();
    check("done_hold", 32'(done), 1);
    valid = 0; run = 0;
  endtask

  // Cancel (abort or reset) in the middle of POST, then confirm a clean idle.
  task automatic cancel_mid_post(input bit use_reset);
    int n;
    n = 0;
    start = 1; cfgRising = 8'hA5; cfgFalling = 8'h5A; post_count = AW'(10); valid = 0; run = 0;
    tick();
    start = 0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      valid = 1; dataIn = SW'($urandom); push_exp(n); n++;
      tick();
    end
    run = 1; valid = 1; dataIn = SW'($urandom); push_exp(n); n++;
    tick();
    run = 0;
    for (int i = 0; i < 2; i++) begin
      valid = 1; dataIn = SW'($urandom); push_exp(n); n++;
      tick();
    end
    check("busy_mid_post", 32'(busy), 1);
    valid = 1; dataIn = SW'($urandom); start = 1; run = 1;
    if (use_reset) reset = 0;
    else abort = 1;
    @(negedge clock);
    check("wr_en_cancel_cycle", 32'(wr_en), 0);
    @(posedge clock);
    #1;
    reset = 1; abort = 0; start = 0; run = 0; valid = 1;
    check("busy_after_cancel", 32'(busy), 0);
    check("done_after_cancel", 32'(done), 0);
    check("load_after_cancel", 32'(load_trigs), 0);
    check("arm_after_cancel", 32'(arm), 0);
    if (use_reset) begin
      check("trig_addr_reset", 32'(trig_addr), 0);
      check("trigRising_reset", 32'(trigRising), 0);
    end
    @(negedge clock);
    check("wr_en_idle", 32'(wr_en), 0);
    @(posedge clock);
    #1;
    valid = 0;
  endtask

  initial begin
    int t;
    bit w, fo;
    tbl[0] = '{3, 6, 1'b1, 100, 6, 1'b0};
    tbl[1] = '{15, 20, 1'b1, 100, 4, 1'b1};
    tbl[2] = '{0, 5, 1'b1, 100, 5, 1'b0};
    tbl[3] = '{0, 3, 1'b0, 100, 3, 1'b0};
    tbl[4] = '{15, 0, 1'b0, 70, 0, 1'b1};
    tbl[5] = '{7, 12, 1'b1, 60, 12, 1'b1};

    fork
      forever begin
        @(negedge clock);
        if (reset === 1'b1 && wr_en === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
          end else begin
            logic [AW+SW-1:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
              errors++;
              $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                       wr_addr, wr_data, e[AW+SW-1:SW], e[SW-1:0]);
            end
          end
        end
      end
    join_none

    reset = 0; start = 0; abort = 0; valid = 1; run = 1;
    dataIn = '0; cfgRising = 8'hFF; cfgFalling = 8'hFF; post_count = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load", 32'(load_trigs), 0);
    check("rst_arm", 32'(arm), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_trig_addr", 32'(trig_addr), 0);
    check("rst_wrapped", 32'(wrapped), 0);
    check("rst_timed_out", 32'(timed_out), 0);
    check("rst_trigRising", 32'(trigRising), 0);
    check("rst_trigFalling", 32'(trigFalling), 0);
    reset = 1; valid = 0; run = 0;
    tick();
    check("idle_busy", 32'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      do_capture(tbl[i].post, tbl[i].pre, tbl[i].vor, tbl[i].pct, t, w, fo);
`ifndef CAPTURE_TIMEOUT_EN
      check($sformatf("tbl%0d_trig", i), 32'(trig_addr), 32'(tbl[i].exp_trig));
      check($sformatf("tbl%0d_wrap", i), 32'(wrapped), 32'(tbl[i].exp_wrap));
`endif
    end

    for (int i = 0; i < 10; i++) begin
      do_capture($urandom_range(0, DEPTH - 1), $urandom_range(0, 25), 1'($urandom),
                 $urandom_range(30, 100), t, w, fo);
    end

    cancel_mid_post(1'b0);
    do_capture(2, 2, 1'b1, 100, t, w, fo);
    check("restart_after_abort", 32'(trig_addr), 2);
    cancel_mid_post(1'b1);
    do_capture(2, 2, 1'b1, 100, t, w, fo);
    check("restart_after_reset", 32'(trig_addr), 2);

`ifdef CAPTURE_TIMEOUT_EN
    do_capture(3, 100, 1'b1, 100, t, w, fo);
    check("timeout_trig_addr", 32'(trig_addr), 8);
    check("timeout_flag", 32'(timed_out), 1);
`else
    do_capture(2, 30, 1'b1, 100, t, w, fo);
    check("no_timeout_trig_addr", 32'(trig_addr), 14);
    check("no_timeout_flag", 32'(timed_out), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/capture_controller.md
CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8, meaning channels per sample.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning sample-memory address width (depth 2^ADDR_WIDTH).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning clock cycles in PRETRIG before a forced trigger (used only with CAPTURE_TIMEOUT_EN).
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on posedge clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports start (in, 1, host capture request pulse) and abort (in, 1, host cancel).
REQ-007 SHALL have ports valid (in, 1, sample strobe) and dataIn (in, SAMPLE_WIDTH, sample bus).
REQ-008 SHALL have ports cfgRising and cfgFalling (in, SAMPLE_WIDTH each, host trigger-edge selections) and post_count (in, ADDR_WIDTH, samples kept after the trigger sample).
REQ-009 SHALL have ports trigRising and trigFalling (out, SAMPLE_WIDTH each), load_trigs (out, 1) and arm (out, 1), all driven to the trigger block.
REQ-010 SHALL have port run (in, 1), the trigger-detected indication from the trigger block.
REQ-011 SHALL have ports wr_en (out, 1), wr_addr (out, ADDR_WIDTH) and wr_data (out, SAMPLE_WIDTH), the sample-memory write port.
REQ-012 SHALL have ports trig_addr (out, ADDR_WIDTH), wrapped (out, 1), busy (out, 1), done (out, 1) and timed_out (out, 1).

Function
REQ-013 SHALL implement states IDLE, LOAD, ARM, PRETRIG, POST and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL register cfgRising/cfgFalling onto trigRising/trigFalling, latch post_count, clear wr_ptr, wrapped, done and timed_out, and go to LOAD; start in any other state SHALL be ignored.
REQ-015 LOAD SHALL last one cycle with load_trigs=1, then go to ARM.
REQ-016 ARM SHALL last one cycle with arm=1, then go to PRETRIG; arm and load_trigs SHALL be 0 in every other state.
REQ-017 run SHALL be ignored in every state except PRETRIG.
REQ-018 In PRETRIG and POST, each cycle with valid=1 SHALL produce wr_en=1, wr_addr=wr_ptr and wr_data=dataIn in the same cycle (combinational from the registered wr_ptr), then increment wr_ptr modulo 2^ADDR_WIDTH; wr_en SHALL be 0 otherwise.
REQ-019 wrapped SHALL set when wr_ptr wraps from 2^ADDR_WIDTH-1 to 0 and hold until the next start.
REQ-020 run=1 in PRETRIG SHALL latch trig_addr=wr_ptr; the trigger sample is the sample written in that cycle if valid=1, otherwise the next valid sample.
REQ-021 On that transition the remaining counter (ADDR_WIDTH+1 bits) SHALL load post_count if valid=1, otherwise post_count+1, and the FSM SHALL go to POST, or directly to DONE if the loaded value is 0.
REQ-022 In POST, each valid write SHALL decrement remaining; the write that takes it to 0 SHALL be the last write, and the FSM SHALL enter DONE the next cycle.
REQ-023 Total writes from the trigger sample through the end SHALL equal post_count+1; post_count=2^ADDR_WIDTH-1 SHALL fill the buffer exactly once without overwriting the trigger sample.
REQ-024 busy SHALL be 1 in LOAD, ARM, PRETRIG and POST; done SHALL be 1 only in DONE and hold until start or reset.
REQ-025 abort=1 in any state SHALL force IDLE the next cycle with wr_en=0, done=0 and busy=0; abort SHALL take priority over start, run and valid in the same cycle.

Reset
REQ-026 reset=0 SHALL force IDLE; wr_ptr, trig_addr, remaining, trigRising and trigFalling to 0; and load_trigs, arm, wr_en, wrapped, busy, done and timed_out to 0, taking priority over all other inputs, including mid-capture.

Configuration
REQ-027 With macro CAPTURE_TIMEOUT_EN defined, a cycle counter SHALL clear on entry to PRETRIG; when it reaches TIMEOUT_CYCLES with no run, the block SHALL behave exactly as if run=1 in that cycle and set timed_out=1 until the next start.
REQ-028 Without CAPTURE_TIMEOUT_EN, the block SHALL contain no timeout counter, timed_out SHALL be tied to 0, and PRETRIG SHALL wait indefinitely for run.

Verification
REQ-029 SHALL cover: ADDR_WIDTH=4, post_count=3, start, valid every cycle, run after 6 writes -> load_trigs at cycle 1, arm at cycle 2, trig_addr=6, writes at addresses 6-9, done=1, wrapped=0.
REQ-030 SHALL cover: ADDR_WIDTH=4, run after 20 writes with post_count=15 -> wrapped=1, trig_addr=4, 16 writes from address 4 through 3, then done=1.
REQ-031 SHALL cover: post_count=0 with run and valid in the same cycle -> exactly one write at trig_addr, DONE the next cycle; with run while valid=0 -> the next valid sample is written at trig_addr, then DONE.
REQ-032 SHALL cover: run held high during LOAD/ARM, then run asserted in PRETRIG -> trigger taken only in PRETRIG; start asserted during POST -> ignored.
REQ-033 SHALL cover: abort, and separately reset=0, asserted mid-POST -> next cycle IDLE, wr_en=0, busy=0, done=0; a subsequent start runs normally from wr_ptr=0.
REQ-034 SHALL cover: CAPTURE_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, run held 0 -> forced trigger 8 cycles after PRETRIG entry and timed_out=1; macro undefined -> remains in PRETRIG with timed_out=0.
